// File: rtl/pc_pkg.sv
// Shared definitions for the fetch-stage next-PC unit: redirect kinds, hold-state
// encoding and the parameter-legality check.
package pc_pkg;

    localparam logic [1:0] KIND_NONE = 2'b00;
    localparam logic [1:0] KIND_BR   = 2'b01;
    localparam logic [1:0] KIND_J    = 2'b10;
    localparam logic [1:0] KIND_JR   = 2'b11;

    typedef enum logic {
        StRun  = 1'b0,
        StHold = 1'b1
    } pc_state_e;

    // The jump index plus alignment bits must fit inside the address.
    function automatic bit pc_params_legal(input int unsigned addr_w,
                                           input int unsigned idx_w,
                                           input int unsigned align);
        return (idx_w + align) <= addr_w;
    endfunction

endpackage

// File: rtl/target_calc.sv
// Combinational redirect-target calculator: branch, jump and jump-register targets
// with a misalignment flag for register targets.
module target_calc
    import pc_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned IDX_W  = 26,
    parameter int unsigned OFF_W  = 16,
    parameter int unsigned ALIGN  = 2
) (
    input  logic [1:0]        kind,
    input  logic [ADDR_W-1:0] base,
    input  logic [OFF_W-1:0]  br_off,
    input  logic [IDX_W-1:0]  j_idx,
    input  logic [ADDR_W-1:0] jr_addr,
    output logic [ADDR_W-1:0] target,
    output logic              fault_bit
);

    localparam logic [ADDR_W-1:0] Step    = {{(ADDR_W-1){1'b0}}, 1'b1} << ALIGN;
    localparam logic [ADDR_W-1:0] LowMask = Step - {{(ADDR_W-1){1'b0}}, 1'b1};
    // Bits above the jump index are inherited from the sequential PC.
    localparam logic [ADDR_W-1:0] HiMask  = {ADDR_W{1'b1}} << (IDX_W + ALIGN);

    logic [ADDR_W-1:0] seq;
    logic [ADDR_W-1:0] off_ext;

    always_comb begin
        seq       = base + Step;
        off_ext   = ADDR_W'($signed(br_off));
        target    = seq;
        fault_bit = 1'b0;
        case (kind)
            KIND_BR: target = seq + (off_ext << ALIGN);
            KIND_J:  target = (seq & HiMask) | (ADDR_W'(j_idx) << ALIGN);
            KIND_JR: begin
                target    = jr_addr & ~LowMask;
                fault_bit = |(jr_addr & LowMask);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/pc_gen.sv
// Registered next-PC unit: sequential advance, live redirects, and a single held
// redirect that waits out a fetch stall.
module pc_gen
    import pc_pkg::*;
#(
    parameter int unsigned     ADDR_W   = 32,
    parameter int unsigned     IDX_W    = 26,
    parameter int unsigned     OFF_W    = 16,
    parameter int unsigned     ALIGN    = 2,
    parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_3000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              redirect_valid,
    input  logic [1:0]        redirect_kind,
    input  logic [ADDR_W-1:0] redirect_base,
    input  logic [OFF_W-1:0]  br_off,
    input  logic [IDX_W-1:0]  j_idx,
    input  logic [ADDR_W-1:0] jr_addr,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_plus,
    output logic              pc_valid,
    output logic              flush,
    output logic              align_fault,
    output logic              pending
);

    if (!pc_params_legal(ADDR_W, IDX_W, ALIGN)) begin : gen_param_check
        $error("pc_gen: IDX_W + ALIGN exceeds ADDR_W");
    end

    localparam logic [ADDR_W-1:0] Step = {{(ADDR_W-1){1'b0}}, 1'b1} << ALIGN;

    logic [ADDR_W-1:0] live_tgt;
    logic              live_fault;
    logic              live;

    pc_state_e         state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] held_tgt_q, held_tgt_d;
    logic              held_fault_q, held_fault_d;
    logic              pc_valid_q, pc_valid_d;
    logic              flush_q, flush_d;
    logic              fault_q, fault_d;

    target_calc #(
        .ADDR_W (ADDR_W),
        .IDX_W  (IDX_W),
        .OFF_W  (OFF_W),
        .ALIGN  (ALIGN)
    ) u_target_calc (
        .kind      (redirect_kind),
        .base      (redirect_base),
        .br_off    (br_off),
        .j_idx     (j_idx),
        .jr_addr   (jr_addr),
        .target    (live_tgt),
        .fault_bit (live_fault)
    );

    assign live = redirect_valid && (redirect_kind != KIND_NONE);

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        held_tgt_d   = held_tgt_q;
        held_fault_d = held_fault_q;
        pc_valid_d   = 1'b1;
        flush_d      = 1'b0;
        fault_d      = 1'b0;
        if (live && !stall) begin
            // A live redirect supersedes anything still held.
            pc_d    = live_tgt;
            flush_d = 1'b1;
            fault_d = live_fault;
            state_d = StRun;
        end else if (state_q == StHold && !stall) begin
            pc_d    = held_tgt_q;
            flush_d = 1'b1;
            fault_d = held_fault_q;
            state_d = StRun;
        end else if (live) begin
            held_tgt_d   = live_tgt;
            held_fault_d = live_fault;
            state_d      = StHold;
        end else if (!stall) begin
            pc_d = pc_q + Step;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StRun;
            pc_q         <= RESET_PC;
            held_tgt_q   <= '0;
            held_fault_q <= 1'b0;
            pc_valid_q   <= 1'b0;
            flush_q      <= 1'b0;
            fault_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            held_tgt_q   <= held_tgt_d;
            held_fault_q <= held_fault_d;
            pc_valid_q   <= pc_valid_d;
            flush_q      <= flush_d;
            fault_q      <= fault_d;
        end
    end

    assign pc          = pc_q;
    assign pc_plus     = pc_q + Step;
    assign pc_valid    = pc_valid_q;
    assign flush       = flush_q;
    assign align_fault = fault_q;
    assign pending     = (state_q == StHold);

endmodule

// File: tb/tb_pc_gen.sv
// Scoreboard bench for pc_gen: the driver pushes model expectations per cycle and a
// monitor pops and compares them against the registered outputs.
module tb_pc_gen;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [1:0]  redirect_kind = 2'b00;
    logic [31:0] redirect_base = '0;
    logic [15:0] br_off = '0;
    logic [25:0] j_idx = '0;
    logic [31:0] jr_addr = '0;
    logic [31:0] pc, pc_plus;
    logic        pc_valid, flush, align_fault, pending;

    pc_gen dut (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_kind  (redirect_kind),
        .redirect_base  (redirect_base),
        .br_off         (br_off),
        .j_idx          (j_idx),
        .jr_addr        (jr_addr),
        .pc             (pc),
        .pc_plus        (pc_plus),
        .pc_valid       (pc_valid),
        .flush          (flush),
        .align_fault    (align_fault),
        .pending        (pending)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic        valid;
        logic        flush;
        logic        fault;
        logic        pending;
    } exp_t;

    typedef struct packed {
        logic [31:0] tgt;
        logic        fault;
    } held_t;

    exp_t  exp_q[$];
    held_t held[$];
    logic [31:0] m_pc = 32'h0000_3000;
    logic        m_valid = 1'b0;
    int n_pass = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    endtask

    // Reference targets straight from the arithmetic definitions.
    task automatic ref_target(input logic [1:0] k, input logic [31:0] b, input logic [15:0] o,
                              input logic [25:0] ji, input logic [31:0] jr,
                              output logic [31:0] tgt, output logic f);
        logic [31:0] seq;
        seq = b + 32'd4;
        f = 1'b0;
        tgt = seq;
        if (k == 2'b01) tgt = seq + 32'(int'($signed(o)) * 4);
        else if (k == 2'b10) tgt = ((seq >> 28) << 28) + {6'b0, ji} * 32'd4;
        else if (k == 2'b11) begin
            tgt = (jr / 32'd4) * 32'd4;
            f = (jr % 32'd4) != 0;
        end
    endtask

    task automatic drive(input logic r, input logic s, input logic rv, input logic [1:0] k,
                         input logic [31:0] b, input logic [15:0] o, input logic [25:0] ji,
                         input logic [31:0] jr);
        exp_t e;
        held_t h;
        logic [31:0] tgt;
        logic f;
        @(negedge clk);
        rst = r; stall = s; redirect_valid = rv; redirect_kind = k;
        redirect_base = b; br_off = o; j_idx = ji; jr_addr = jr;
        ref_target(k, b, o, ji, jr, tgt, f);
        e.flush = 1'b0;
        e.fault = 1'b0;
        if (r) begin
            m_pc = 32'h0000_3000;
            m_valid = 1'b0;
            held.delete();
        end else begin
            m_valid = 1'b1;
            if (rv && k != 2'b00 && !s) begin
                m_pc = tgt; e.flush = 1'b1; e.fault = f;
                held.delete();
            end else if (held.size() != 0 && !s) begin
                h = held.pop_front();
                m_pc = h.tgt; e.flush = 1'b1; e.fault = h.fault;
            end else if (rv && k != 2'b00) begin
                held.delete();
                held.push_back('{tgt: tgt, fault: f});
            end else if (!s) begin
                m_pc = m_pc + 32'd4;
            end
        end
        e.pc = m_pc;
        e.valid = m_valid;
        e.pending = held.size() != 0;
        exp_q.push_back(e);
    endtask

    task automatic idle(input logic s);
        drive(1'b0, s, 1'b0, 2'b00, '0, '0, '0, '0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("pc", pc, e.pc);
                check("pc_plus", pc_plus, e.pc + 32'd4);
                check("pc_valid", 32'(pc_valid), 32'(e.valid));
                check("flush", 32'(flush), 32'(e.flush));
                check("align_fault", 32'(align_fault), 32'(e.fault));
                check("pending", 32'(pending), 32'(e.pending));
            end
        end
    end

    initial begin : driver
        drive(1'b1, 1'b0, 1'b0, 2'b00, '0, '0, '0, '0);
        for (int i = 0; i < 4; i++) idle(1'b0);
        drive(1'b0, 1'b0, 1'b1, 2'b01, 32'h0000_3010, 16'hFFFC, '0, '0);
        idle(1'b0);
        drive(1'b0, 1'b0, 1'b1, 2'b10, 32'h3FFF_FFFC, '0, 26'h000_0100, '0);
        drive(1'b0, 1'b0, 1'b1, 2'b11, '0, '0, '0, 32'h0040_0006);
        idle(1'b0);
        drive(1'b0, 1'b1, 1'b1, 2'b01, 32'h0000_30FC, 16'h0000, '0, '0);
        drive(1'b0, 1'b1, 1'b1, 2'b10, 32'h0000_0000, '0, 26'h000_0100, '0);
        idle(1'b1);
        idle(1'b0);
        idle(1'b0);
        drive(1'b0, 1'b1, 1'b1, 2'b11, '0, '0, '0, 32'h1234_5679);
        drive(1'b1, 1'b1, 1'b0, 2'b00, '0, '0, '0, '0);
        idle(1'b0);
        drive(1'b0, 1'b0, 1'b1, 2'b11, '0, '0, '0, 32'hFFFF_FFFC);
        idle(1'b0);
        drive(1'b0, 1'b0, 1'b1, 2'b00, 32'h0000_8000, 16'h0010, 26'h3, 32'h40);
        drive(1'b0, 1'b0, 1'b1, 2'b01, 32'h0000_0100, 16'h0001, '0, '0);
        drive(1'b0, 1'b0, 1'b1, 2'b10, 32'hF000_0000, '0, 26'h3FF_FFFF, '0);
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 49) == 0, $urandom_range(0, 9) < 3,
                  $urandom_range(0, 9) < 5, 2'($urandom), $urandom, 16'($urandom),
                  26'($urandom), $urandom);
        end
        repeat (2) @(negedge clk);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
